// File: rtl/mem_seq_pkg.sv
// Shared op codes, sequencer state encoding and strobe bundle for mem_sequencer.
package mem_seq_pkg;

    localparam logic [2:0] OP_FETCH = 3'd0;
    localparam logic [2:0] OP_JMPI  = 3'd1;
    localparam logic [2:0] OP_CALL  = 3'd2;
    localparam logic [2:0] OP_RET   = 3'd3;
    localparam logic [2:0] OP_LDMAR = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_F_LATCH,
        ST_F_INC,
        ST_JMPI,
        ST_C_SPDEC,
        ST_C_WRITE,
        ST_C_JUMP,
        ST_R_READ,
        ST_R_SPINC,
        ST_M_LO,
        ST_M_HI
    } state_t;

    typedef struct packed {
        logic pc_load_n;
        logic pc_n_en;
        logic mem_pc_to_ram_n;
        logic sp_n_en;
        logic instr_n_we;
        logic instr_n_oe;
        logic ram_n_oe;
        logic ram_n_we;
        logic mar0_n_we;
        logic mar1_n_we;
        logic pc_from_imm;
        logic sp_up;
        logic imm_to_ram_addr;
        logic done;
    } strobe_t;

    localparam strobe_t STROBE_IDLE = '{
        pc_load_n:       1'b1,
        pc_n_en:         1'b1,
        mem_pc_to_ram_n: 1'b1,
        sp_n_en:         1'b1,
        instr_n_we:      1'b1,
        instr_n_oe:      1'b1,
        ram_n_oe:        1'b1,
        ram_n_we:        1'b1,
        mar0_n_we:       1'b1,
        mar1_n_we:       1'b1,
        pc_from_imm:     1'b0,
        sp_up:           1'b0,
        imm_to_ram_addr: 1'b0,
        done:            1'b0
    };

endpackage

// File: rtl/mem_seq_strobe_dec.sv
// Moore strobe map: sequencer state and halt to the memory-block control strobes.
module mem_seq_strobe_dec
    import mem_seq_pkg::*;
(
    input  state_t  state,
    input  logic    halt,
    output strobe_t strobes
);

    always_comb begin
        strobes = STROBE_IDLE;
        if (!halt) begin
            case (state)
                ST_F_LATCH: strobes.instr_n_we = 1'b0;
                ST_F_INC: begin
                    strobes.pc_n_en = 1'b0;
                    strobes.done    = 1'b1;
                end
                ST_JMPI, ST_C_JUMP: begin
                    strobes.pc_load_n   = 1'b0;
                    strobes.pc_from_imm = 1'b1;
                    strobes.done        = 1'b1;
                end
                ST_C_SPDEC: begin
                    strobes.sp_n_en = 1'b0;
                    strobes.sp_up   = 1'b0;
                end
                ST_C_WRITE: begin
                    strobes.mem_pc_to_ram_n = 1'b0;
                    strobes.ram_n_we        = 1'b0;
                    strobes.imm_to_ram_addr = 1'b1;
                end
                // Return loads the PC from RAM data, hence pc_from_imm stays low.
                ST_R_READ: begin
                    strobes.ram_n_oe        = 1'b0;
                    strobes.imm_to_ram_addr = 1'b1;
                    strobes.pc_load_n       = 1'b0;
                    strobes.pc_from_imm     = 1'b0;
                end
                ST_R_SPINC: begin
                    strobes.sp_n_en = 1'b0;
                    strobes.sp_up   = 1'b1;
                    strobes.done    = 1'b1;
                end
                ST_M_LO: strobes.mar0_n_we = 1'b0;
                ST_M_HI: begin
                    strobes.mar1_n_we = 1'b0;
                    strobes.done      = 1'b1;
                end
                default: strobes = STROBE_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_sequencer.sv
// Memory-operation micro-sequencer: FSM and start handshake. Optional breakpoint
// trap on FETCH enabled by defining MEMSEQ_BREAK_EN.
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned OP_W = 3
)
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [OP_W-1:0] i_op,
    input  logic            i_halt,
`ifdef MEMSEQ_BREAK_EN
    input  logic            i_breakpointHitN,
    input  logic            i_breakClear,
    output logic            o_break,
`endif
    output logic            o_ready,
    output logic            o_done,
    output logic            o_illegal,
    output logic            o_ctrlPCLoadN,
    output logic            o_ctrlPCNEn,
    output logic            o_ctrlMemPCToRamN,
    output logic            o_ctrlSpNEn,
    output logic            o_ctrlInstrNWE,
    output logic            o_ctrlInstrNOE,
    output logic            o_ctrlRamNOE,
    output logic            o_ctrlRamNWE,
    output logic            o_ctrlMemMar0NWE,
    output logic            o_ctrlMemMar1NWE,
    output logic            o_ctrlPCFromImm,
    output logic            o_ctrlSpUp,
    output logic            o_ctrlMemInstrImmToRamAddr
);

    state_t  state, state_next;
    logic    illegal_q, illegal_next;
    logic    accept;
    strobe_t strobes;

`ifdef MEMSEQ_BREAK_EN
    logic brk_q, brk_next;
    logic brk_done_q, brk_done_next;

    assign o_ready = (state == ST_IDLE) && !brk_q;
    assign o_break = brk_q;
`else
    assign o_ready = (state == ST_IDLE);
`endif

    assign accept = i_start && o_ready && !i_halt;

    always_comb begin
        state_next   = state;
        illegal_next = 1'b0;
`ifdef MEMSEQ_BREAK_EN
        brk_next      = brk_q && !i_breakClear;
        brk_done_next = 1'b0;
`endif
        if (state == ST_IDLE) begin
            if (accept) begin
                case (i_op)
`ifdef MEMSEQ_BREAK_EN
                    // A trapped fetch completes immediately without touching memory.
                    OP_W'(OP_FETCH): begin
                        if (!i_breakpointHitN) begin
                            brk_next      = 1'b1;
                            brk_done_next = 1'b1;
                        end else begin
                            state_next = ST_F_LATCH;
                        end
                    end
`else
                    OP_W'(OP_FETCH): state_next = ST_F_LATCH;
`endif
                    OP_W'(OP_JMPI):  state_next = ST_JMPI;
                    OP_W'(OP_CALL):  state_next = ST_C_SPDEC;
                    OP_W'(OP_RET):   state_next = ST_R_READ;
                    OP_W'(OP_LDMAR): state_next = ST_M_LO;
                    default:         illegal_next = 1'b1;
                endcase
            end
        end else if (!i_halt) begin
            case (state)
                ST_F_LATCH: state_next = ST_F_INC;
                ST_C_SPDEC: state_next = ST_C_WRITE;
                ST_C_WRITE: state_next = ST_C_JUMP;
                ST_R_READ:  state_next = ST_R_SPINC;
                ST_M_LO:    state_next = ST_M_HI;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            illegal_q <= 1'b0;
`ifdef MEMSEQ_BREAK_EN
            brk_q      <= 1'b0;
            brk_done_q <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            illegal_q <= illegal_next;
`ifdef MEMSEQ_BREAK_EN
            brk_q      <= brk_next;
            brk_done_q <= brk_done_next;
`endif
        end
    end

    mem_seq_strobe_dec u_dec (
        .state   (state),
        .halt    (i_halt),
        .strobes (strobes)
    );

    assign o_illegal = illegal_q;
`ifdef MEMSEQ_BREAK_EN
    assign o_done = strobes.done || (brk_done_q && !i_halt);
`else
    assign o_done = strobes.done;
`endif

    assign o_ctrlPCLoadN              = strobes.pc_load_n;
    assign o_ctrlPCNEn                = strobes.pc_n_en;
    assign o_ctrlMemPCToRamN          = strobes.mem_pc_to_ram_n;
    assign o_ctrlSpNEn                = strobes.sp_n_en;
    assign o_ctrlInstrNWE             = strobes.instr_n_we;
    assign o_ctrlInstrNOE             = strobes.instr_n_oe;
    assign o_ctrlRamNOE               = strobes.ram_n_oe;
    assign o_ctrlRamNWE               = strobes.ram_n_we;
    assign o_ctrlMemMar0NWE           = strobes.mar0_n_we;
    assign o_ctrlMemMar1NWE           = strobes.mar1_n_we;
    assign o_ctrlPCFromImm            = strobes.pc_from_imm;
    assign o_ctrlSpUp                 = strobes.sp_up;
    assign o_ctrlMemInstrImmToRamAddr = strobes.imm_to_ram_addr;

endmodule

// File: tb/tb_mem_sequencer.sv
// Bench for mem_sequencer: directed sequences with literal expectations, then
// randomized traffic checked each cycle against an op-sequence queue model.
module tb_mem_sequencer;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_start = 1'b0;
    logic [2:0] i_op = 3'd0;
    logic       i_halt = 1'b0;
    logic       brk_hit_n = 1'b1;
    logic       brk_clr = 1'b0;
    logic       o_break;
    logic       o_ready, o_done, o_illegal;
    logic       pc_load_n, pc_n_en, mem_pc_to_ram_n, sp_n_en, instr_n_we, instr_n_oe;
    logic       ram_n_oe, ram_n_we, mar0_n_we, mar1_n_we, pc_from_imm, sp_up, imm_addr;

    int n_cmp = 0;
    int n_bad = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    mem_sequencer #(.OP_W(3)) dut (
        .i_clk                      (clk),
        .i_reset                    (i_reset),
        .i_start                    (i_start),
        .i_op                       (i_op),
        .i_halt                     (i_halt),
`ifdef MEMSEQ_BREAK_EN
        .i_breakpointHitN           (brk_hit_n),
        .i_breakClear               (brk_clr),
        .o_break                    (o_break),
`endif
        .o_ready                    (o_ready),
        .o_done                     (o_done),
        .o_illegal                  (o_illegal),
        .o_ctrlPCLoadN              (pc_load_n),
        .o_ctrlPCNEn                (pc_n_en),
        .o_ctrlMemPCToRamN          (mem_pc_to_ram_n),
        .o_ctrlSpNEn                (sp_n_en),
        .o_ctrlInstrNWE             (instr_n_we),
        .o_ctrlInstrNOE             (instr_n_oe),
        .o_ctrlRamNOE               (ram_n_oe),
        .o_ctrlRamNWE               (ram_n_we),
        .o_ctrlMemMar0NWE           (mar0_n_we),
        .o_ctrlMemMar1NWE           (mar1_n_we),
        .o_ctrlPCFromImm            (pc_from_imm),
        .o_ctrlSpUp                 (sp_up),
        .o_ctrlMemInstrImmToRamAddr (imm_addr)
    );

`ifndef MEMSEQ_BREAK_EN
    assign o_break = 1'b0;
`endif

    // Strobe word: ten active-low strobes, three active-high selects, done.
    localparam logic [13:0] INACT      = 14'b1111111111_0000;
    localparam logic [13:0] M_PCLOAD   = 14'h2000;
    localparam logic [13:0] M_PCNEN    = 14'h1000;
    localparam logic [13:0] M_MEMPC    = 14'h0800;
    localparam logic [13:0] M_SPNEN    = 14'h0400;
    localparam logic [13:0] M_INSTRNWE = 14'h0200;
    localparam logic [13:0] M_RAMNOE   = 14'h0080;
    localparam logic [13:0] M_RAMNWE   = 14'h0040;
    localparam logic [13:0] M_MAR0     = 14'h0020;
    localparam logic [13:0] M_MAR1     = 14'h0010;
    localparam logic [13:0] M_PCIMM    = 14'h0008;
    localparam logic [13:0] M_SPUP     = 14'h0004;
    localparam logic [13:0] M_IMMADDR  = 14'h0002;
    localparam logic [13:0] M_DONE     = 14'h0001;

    localparam logic [13:0] P_FLATCH = INACT & ~M_INSTRNWE;
    localparam logic [13:0] P_FINC   = (INACT & ~M_PCNEN) | M_DONE;
    localparam logic [13:0] P_JUMP   = (INACT & ~M_PCLOAD) | M_PCIMM | M_DONE;
    localparam logic [13:0] P_SPDEC  = INACT & ~M_SPNEN;
    localparam logic [13:0] P_CWRITE = (INACT & ~(M_MEMPC | M_RAMNWE)) | M_IMMADDR;
    localparam logic [13:0] P_RREAD  = (INACT & ~(M_RAMNOE | M_PCLOAD)) | M_IMMADDR;
    localparam logic [13:0] P_RSPINC = (INACT & ~M_SPNEN) | M_SPUP | M_DONE;
    localparam logic [13:0] P_MLO    = INACT & ~M_MAR0;
    localparam logic [13:0] P_MHI    = (INACT & ~M_MAR1) | M_DONE;

    function automatic logic [16:0] dut_vec();
        return {o_break, o_ready, o_illegal,
                pc_load_n, pc_n_en, mem_pc_to_ram_n, sp_n_en, instr_n_we, instr_n_oe,
                ram_n_oe, ram_n_we, mar0_n_we, mar1_n_we, pc_from_imm, sp_up, imm_addr, o_done};
    endfunction

    function automatic logic [16:0] ev(logic brk, logic rdy, logic ill, logic [13:0] s);
        return {brk, rdy, ill, s};
    endfunction

    // Reference model: remaining strobe words of the operation in flight.
    logic [13:0] mq[$];
    bit illegal_m = 1'b0;
    bit brk_m = 1'b0;
    bit bdone_m = 1'b0;

    always @(negedge clk) begin
        logic [13:0] cur;
        logic [16:0] exp_v, got_v;
        bit rdy, acc;
        cur = (mq.size() != 0) ? mq[0] : INACT;
        if (bdone_m) cur = cur | M_DONE;
        if (i_halt) cur = INACT;
        rdy = (mq.size() == 0) && !brk_m;
        exp_v = ev(brk_m, rdy, illegal_m, cur);
        if (model_on) begin
            got_v = dut_vec();
            n_cmp++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL model_cycle t=%0t: got %h expected %h", $time, got_v, exp_v);
            end
        end
        acc = i_start && rdy && !i_halt;
        if (i_reset) begin
            mq.delete();
            illegal_m = 1'b0;
            brk_m = 1'b0;
            bdone_m = 1'b0;
        end else begin
            illegal_m = 1'b0;
            bdone_m = 1'b0;
`ifdef MEMSEQ_BREAK_EN
            if (brk_clr) brk_m = 1'b0;
`endif
            if (mq.size() != 0) begin
                if (!i_halt) void'(mq.pop_front());
            end else if (acc) begin
                case (i_op)
                    3'd0: begin
`ifdef MEMSEQ_BREAK_EN
                        if (!brk_hit_n) begin
                            brk_m = 1'b1;
                            bdone_m = 1'b1;
                        end else begin
                            mq.push_back(P_FLATCH);
                            mq.push_back(P_FINC);
                        end
`else
                        mq.push_back(P_FLATCH);
                        mq.push_back(P_FINC);
`endif
                    end
                    3'd1: mq.push_back(P_JUMP);
                    3'd2: begin
                        mq.push_back(P_SPDEC);
                        mq.push_back(P_CWRITE);
                        mq.push_back(P_JUMP);
                    end
                    3'd3: begin
                        mq.push_back(P_RREAD);
                        mq.push_back(P_RSPINC);
                    end
                    3'd4: begin
                        mq.push_back(P_MLO);
                        mq.push_back(P_MHI);
                    end
                    default: illegal_m = 1'b1;
                endcase
            end
        end
    end

    // Drive one cycle's inputs, optionally check outputs for that cycle, then clock.
    task automatic step(input logic s, input logic [2:0] op, input logic h, input logic r,
                        input logic chk, input logic [16:0] exp_v, input string name);
        logic [16:0] got_v;
        i_start = s;
        i_op = op;
        i_halt = h;
        i_reset = r;
        #1;
        if (chk) begin
            got_v = dut_vec();
            n_cmp++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", name, got_v, exp_v);
            end
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [16:0] IDLE_V = {1'b0, 1'b1, 1'b0, INACT};

    initial begin
        step(1, 3'd2, 0, 1, 0, '0, "");
        step(1, 3'd2, 0, 1, 0, '0, "");
        model_on = 1'b1;

        step(1, 3'd0, 0, 0, 1, IDLE_V, "reset_idle");
        step(0, 3'd0, 0, 0, 1, ev(0, 0, 0, P_FLATCH), "fetch_latch");
        step(0, 3'd0, 0, 0, 1, ev(0, 0, 0, P_FINC), "fetch_inc");
        step(0, 3'd0, 0, 0, 1, IDLE_V, "fetch_ready");

        step(1, 3'd2, 0, 0, 1, IDLE_V, "call_idle");
        step(0, 3'd0, 0, 0, 1, ev(0, 0, 0, P_SPDEC), "call_spdec");
        step(0, 3'd0, 0, 0, 1, ev(0, 0, 0, P_CWRITE), "call_write");
        step(0, 3'd0, 0, 0, 1, ev(0, 0, 0, P_JUMP), "call_jump");
        step(0, 3'd0, 0, 0, 1, IDLE_V, "call_end");

        step(1, 3'd1, 0, 0, 1, IDLE_V, "jmpi_idle");
        step(0, 3'd0, 0, 0, 1, ev(0, 0, 0, P_JUMP), "jmpi");

        step(1, 3'd3, 0, 0, 1, IDLE_V, "ret_idle");
        step(1, 3'd4, 0, 0, 1, ev(0, 0, 0, P_RREAD), "ret_read");
        step(1, 3'd4, 0, 0, 1, ev(0, 0, 0, P_RSPINC), "ret_spinc");
        step(1, 3'd4, 0, 0, 1, IDLE_V, "ldmar_wait");
        step(0, 3'd0, 0, 0, 1, ev(0, 0, 0, P_MLO), "ldmar_lo");
        step(0, 3'd0, 0, 0, 1, ev(0, 0, 0, P_MHI), "ldmar_hi");
        step(0, 3'd0, 0, 0, 1, IDLE_V, "ldmar_end");

        step(1, 3'd2, 0, 0, 0, '0, "");
        step(0, 3'd0, 0, 0, 1, ev(0, 0, 0, P_SPDEC), "halt_spdec");
        for (int i = 0; i < 3; i++)
            step(0, 3'd0, 1, 0, 1, ev(0, 0, 0, INACT), "halt_write");
        step(0, 3'd0, 0, 0, 1, ev(0, 0, 0, P_CWRITE), "halt_resume");
        step(0, 3'd0, 0, 0, 1, ev(0, 0, 0, P_JUMP), "halt_jump");

        step(1, 3'd6, 0, 0, 1, IDLE_V, "illegal_idle");
        step(0, 3'd0, 0, 0, 1, ev(0, 1, 1, INACT), "illegal_pulse");
        step(0, 3'd0, 0, 0, 1, IDLE_V, "illegal_clear");

        step(1, 3'd2, 0, 0, 0, '0, "");
        step(0, 3'd0, 0, 0, 0, '0, "");
        step(0, 3'd0, 0, 0, 0, '0, "");
        step(0, 3'd0, 0, 1, 1, ev(0, 0, 0, P_JUMP), "reset_in_jump");
        step(0, 3'd0, 0, 0, 1, IDLE_V, "reset_after_jump");

`ifdef MEMSEQ_BREAK_EN
        brk_hit_n = 1'b0;
        step(1, 3'd0, 0, 0, 1, IDLE_V, "brk_accept");
        step(0, 3'd0, 0, 0, 1, ev(1, 0, 0, INACT | M_DONE), "brk_done");
        step(1, 3'd0, 0, 0, 1, ev(1, 0, 0, INACT), "brk_sticky");
        brk_hit_n = 1'b1;
        brk_clr = 1'b1;
        step(0, 3'd0, 0, 0, 1, ev(1, 0, 0, INACT), "brk_clearing");
        brk_clr = 1'b0;
        step(0, 3'd0, 0, 0, 1, IDLE_V, "brk_cleared");
`endif

        for (int n = 0; n < 3000; n++) begin
            logic s, h, r;
            logic [2:0] op;
            s = ($urandom_range(0, 9) < 7);
            h = ($urandom_range(0, 99) < 15);
            r = ($urandom_range(0, 99) < 2);
            op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            brk_hit_n = ($urandom_range(0, 9) < 8);
            brk_clr = ($urandom_range(0, 99) < 5);
            step(s, op, h, r, 0, '0, "");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
